// File: rtl/csr_initiator.sv
// Bus-master for the sensor CSR bus: writes a boot configuration after reset, then
// serves host commands one at a time, rejecting illegal control-register writes.
module csr_initiator #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned DATA_W        = 32,
  parameter bit          INIT_EN       = 1'b1,
  parameter logic [15:0] INIT_FFT_SIZE = 16'd1024,
  parameter logic [15:0] INIT_THRESH   = 16'd100,
  parameter logic        INIT_ENABLE   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              csr_cs,
  output logic              csr_we,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [DATA_W-1:0] csr_wdata,
  input  logic [DATA_W-1:0] csr_rdata,
  output logic              init_done,
  output logic [7:0]        rej_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_FFT  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_THR  = ADDR_W'(8);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t            r_state;
  logic [1:0]        r_step;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_csr_cs;
  logic              r_csr_we;
  logic [ADDR_W-1:0] r_csr_addr;
  logic [DATA_W-1:0] r_csr_wdata;
  logic              r_init_done;
  logic [7:0]        r_rej_cnt;

  logic [ADDR_W-1:0] w_init_addr;
  logic [DATA_W-1:0] w_init_data;
  logic [15:0]       w_v;
  logic              w_fft_ok;
  logic              w_reject;

  // Boot write sequence: FFT size, threshold, then enable last.
  always_comb begin
    w_init_addr = ADDR_CTRL;
    w_init_data = '0;
    case (r_step)
      2'd0: begin
        w_init_addr = ADDR_FFT;
        w_init_data = DATA_W'(INIT_FFT_SIZE);
      end
      2'd1: begin
        w_init_addr = ADDR_THR;
        w_init_data = DATA_W'(INIT_THRESH);
      end
      default: begin
        w_init_addr = ADDR_CTRL;
        w_init_data = DATA_W'(INIT_ENABLE);
      end
    endcase
  end

  // FFT size must be a power of two in 16..32768; threshold must fit in 15 bits.
  assign w_v      = cmd_wdata[15:0];
  assign w_fft_ok = (w_v != 16'd0) && ((w_v & (w_v - 16'd1)) == 16'd0) && (w_v >= 16'd16);
  assign w_reject = (cmd_addr[1:0] != 2'b00) ||
                    (cmd_we && (cmd_addr == ADDR_FFT) && !w_fft_ok) ||
                    (cmd_we && (cmd_addr == ADDR_THR) && (w_v > 16'h7FFF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_step      <= 2'd0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_csr_cs    <= 1'b0;
      r_csr_we    <= 1'b0;
      r_csr_addr  <= '0;
      r_csr_wdata <= '0;
      r_init_done <= 1'b0;
      r_rej_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (!INIT_EN || (r_step == 2'd3)) begin
            r_csr_cs    <= 1'b0;
            r_csr_we    <= 1'b0;
            r_csr_addr  <= '0;
            r_csr_wdata <= '0;
            r_init_done <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_csr_cs    <= 1'b1;
            r_csr_we    <= 1'b1;
            r_csr_addr  <= w_init_addr;
            r_csr_wdata <= w_init_data;
            r_step      <= r_step + 2'd1;
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            r_cmd_ready <= 1'b0;
            if (w_reject) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              if (r_rej_cnt != 8'hFF) r_rej_cnt <= r_rej_cnt + 8'd1;
              r_state     <= S_RESP;
            end else begin
              r_csr_cs    <= 1'b1;
              r_csr_we    <= cmd_we;
              r_csr_addr  <= cmd_addr;
              r_csr_wdata <= cmd_wdata;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_csr_cs    <= 1'b0;
          r_csr_we    <= 1'b0;
          r_csr_addr  <= '0;
          r_csr_wdata <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= r_csr_we ? '0 : csr_rdata;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign csr_cs    = r_csr_cs;
  assign csr_we    = r_csr_we;
  assign csr_addr  = r_csr_addr;
  assign csr_wdata = r_csr_wdata;
  assign init_done = r_init_done;
  assign rej_cnt   = r_rej_cnt;

endmodule
